// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit handshake among NUM_REQ
// requesters. A winner's byte and parity mode are captured in IDLE, offered
// in SEND until the transmitter accepts, and held through WAIT_DONE until the
// frame completes or the done-timeout aborts it. Priority then rotates.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int DONE_TIMEOUT = 2048,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_parity_per_byte,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_parity_per_byte,
  input  logic                          tx_ready,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_err
);

  localparam int CNT_W = $clog2(DONE_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [CNT_W-1:0] cnt;
  logic            found;
  logic [ID_W-1:0] winner;

  // Pick the first pending requester scanning upward from last_grant+1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Accept pulse for the winner, only while idle; no other inputs involved.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Arbitration FSM: capture in IDLE, offer in SEND, hold and time out in WAIT_DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      last_grant         <= ID_W'(NUM_REQ - 1);
      grant_id           <= '0;
      tx_data            <= '0;
      tx_parity_per_byte <= 1'b0;
      tx_valid           <= 1'b0;
      busy               <= 1'b0;
      timeout_err        <= 1'b0;
      cnt                <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id           <= winner;
            tx_data            <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            tx_parity_per_byte <= req_parity_per_byte[winner];
            tx_valid           <= 1'b1;
            busy               <= 1'b1;
            state              <= SEND;
          end
        end
        SEND: begin
          // tx_done is deliberately ignored here; only the handshake matters.
          if (tx_ready) begin
            tx_valid <= 1'b0;
            cnt      <= '0;
            state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // tx_done takes precedence over a coinciding timeout.
          if (tx_done) begin
            last_grant <= grant_id;
            cnt        <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            cnt         <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single-frame grants plus hand-written
// sequences for round-robin, backpressure, timeout, reset and withdrawal.
// Expected transfers are queued when stimulus is driven and checked when the
// DUT completes a tx_valid/tx_ready handshake.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_parity_per_byte = '0;
  logic [N-1:0]  req_ready;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_parity_per_byte;
  logic          tx_ready = 1'b0;
  logic          tx_done = 1'b0;
  logic          busy;
  logic [1:0]    grant_id;
  logic          timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_parity_per_byte(req_parity_per_byte), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_parity_per_byte(tx_parity_per_byte),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         id;
  } exp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  par;
    int          exp_id;
    int          dly;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   rdy_cnt[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] p, input int id);
    exp_t e;
    e.data = d[id*8 +: 8];
    e.par  = p[id];
    e.id   = id;
    sb.push_back(e);
  endtask

  // Transfer monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected: got data %0h want no transfer", tx_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("xfer_data", 32'(tx_data), 32'(e.data));
          check("xfer_parity", 32'(tx_parity_per_byte), 32'(e.par));
          check("xfer_id", 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic clear_rdy();
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_parity_per_byte = '0;
    tx_ready = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_rdy();
  endtask

  // Entered at posedge+1 of the SEND cycle with tx_ready high.
  task automatic complete(input int dly);
    @(posedge clk); #1;
    repeat (dly) begin @(posedge clk); #1; end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("done_busy_low", 32'(busy), 32'd0);
    check("done_tx_valid_low", 32'(tx_valid), 32'd0);
  endtask

  task automatic run_frame(input vec_t v);
    int sum;
    clear_rdy();
    @(posedge clk); #1;
    req_valid = v.valid;
    req_data = v.data;
    req_parity_per_byte = v.par;
    tx_ready = 1'b1;
    push_exp(v.data, v.par, v.exp_id);
    @(negedge clk);
    check("vec_req_ready", 32'(req_ready), 32'(1) << v.exp_id);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("vec_send_valid", 32'(tx_valid), 32'd1);
    check("vec_grant_id", 32'(grant_id), 32'(v.exp_id));
    @(posedge clk); #1;
    @(negedge clk);
    check("vec_wait_valid_low", 32'(tx_valid), 32'd0);
    check("vec_wait_data_held", 32'(tx_data), 32'(v.data[v.exp_id*8 +: 8]));
    repeat (v.dly) begin @(posedge clk); #1; end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("vec_busy_low", 32'(busy), 32'd0);
    sum = 0;
    for (int i = 0; i < N; i++) sum += rdy_cnt[i];
    check("vec_one_ready_pulse", 32'(rdy_cnt[v.exp_id]), 32'd1);
    check("vec_total_ready_pulses", 32'(sum), 32'd1);
  endtask

  initial begin
    vecs[0] = '{4'b0100, 32'h11A5_2233, 4'b0100, 2, 0};
    vecs[1] = '{4'b1111, 32'h5A01_0203, 4'b1000, 3, 1};
    vecs[2] = '{4'b1111, 32'h0405_06C7, 4'b0001, 0, 2};
    vecs[3] = '{4'b0110, 32'h0809_E00A, 4'b0000, 1, 3};
    vecs[4] = '{4'b0101, 32'h0B7E_0C0D, 4'b0100, 2, 4};
    vecs[5] = '{4'b0001, 32'hFFFF_FF00, 4'b1110, 0, 5};
    vecs[6] = '{4'b1000, 32'h8100_0000, 4'b1000, 3, 0};
    vecs[7] = '{4'b1011, 32'h0000_0042, 4'b0001, 0, 2};

    // Reset values
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_parity", 32'(tx_parity_per_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Table-driven frames
    reset_dut();
    for (int k = 0; k < 8; k++) run_frame(vecs[k]);

    // Round-robin with all requesters held high
    reset_dut();
    @(posedge clk); #1;
    req_valid = 4'hF;
    req_data = 32'h4433_2211;
    req_parity_per_byte = 4'b1010;
    tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_exp(req_data, req_parity_per_byte, k % 4);
      @(negedge clk);
      check("rr_req_ready", 32'(req_ready), 32'(1) << (k % 4));
      check("rr_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rr_send_valid", 32'(tx_valid), 32'd1);
      check("rr_grant_id", 32'(grant_id), 32'(k % 4));
      @(posedge clk); #1;
      repeat (4) begin @(posedge clk); #1; end
      tx_done = 1'b1;
      if (k == 4) req_valid = '0;
      @(posedge clk); #1;
      tx_done = 1'b0;
    end
    @(negedge clk);
    check("rr_final_busy", 32'(busy), 32'd0);

    // Backpressure: tx_ready low for a long stretch in SEND
    reset_dut();
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data = 32'h0000_003C;
    req_parity_per_byte = 4'b0001;
    tx_ready = 1'b0;
    push_exp(req_data, req_parity_per_byte, 0);
    @(negedge clk);
    check("bp_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    req_data = '1;
    req_parity_per_byte = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(tx_valid), 32'd1);
      check("bp_data_held", 32'(tx_data), 32'h3C);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("bp_after_xfer_valid", 32'(tx_valid), 32'd0);
    check("bp_after_xfer_data", 32'(tx_data), 32'h3C);
    check("bp_after_xfer_par", 32'(tx_parity_per_byte), 32'd1);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("bp_busy_low", 32'(busy), 32'd0);

    // Timeout, then a frame where tx_done coincides with the timeout
    reset_dut();
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data = 32'h0000_5577;
    req_parity_per_byte = 4'b0010;
    tx_ready = 1'b1;
    push_exp(req_data, req_parity_per_byte, 0);
    @(negedge clk);
    check("to_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 4'b0011;
    @(posedge clk); #1;
    repeat (TO - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    check("to_not_yet", 32'(timeout_err), 32'd0);
    check("to_still_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    push_exp(req_data, req_parity_per_byte, 1);
    @(negedge clk);
    check("to_err_pulse", 32'(timeout_err), 32'd1);
    check("to_idle_busy", 32'(busy), 32'd0);
    check("to_next_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("to_err_one_cycle", 32'(timeout_err), 32'd0);
    check("to_next_id", 32'(grant_id), 32'd1);
    @(posedge clk); #1;
    repeat (TO - 1) begin @(posedge clk); #1; end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("tie_no_err", 32'(timeout_err), 32'd0);
    check("tie_busy_low", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("tie_no_err_late", 32'(timeout_err), 32'd0);

    // Reset asserted during WAIT_DONE
    reset_dut();
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data = 32'h00C3_0000;
    req_parity_per_byte = 4'b0100;
    tx_ready = 1'b1;
    push_exp(req_data, req_parity_per_byte, 2);
    @(negedge clk);
    check("mr_req_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mr_pre_data", 32'(tx_data), 32'hC3);
    #2 rst = 1'b1;
    #1;
    check("mr_tx_valid", 32'(tx_valid), 32'd0);
    check("mr_tx_data", 32'(tx_data), 32'd0);
    check("mr_parity", 32'(tx_parity_per_byte), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_grant_id", 32'(grant_id), 32'd0);
    check("mr_req_ready_rst", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b1010;
    req_data = 32'h0000_9900;
    req_parity_per_byte = 4'b0000;
    push_exp(req_data, req_parity_per_byte, 1);
    @(negedge clk);
    check("mr_first_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    complete(0);

    // Withdrawal of requester 1 before its grant
    reset_dut();
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data = 32'h6600_0011;
    req_parity_per_byte = 4'b1000;
    tx_ready = 1'b1;
    push_exp(req_data, req_parity_per_byte, 0);
    @(negedge clk);
    check("wd_first_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    @(posedge clk); #1;
    @(negedge clk);
    check("wd_no_ready_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    tx_done = 1'b1;
    push_exp(req_data, req_parity_per_byte, 3);
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("wd_grant_3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    complete(1);
    check("wd_never_ready_1", 32'(rdy_cnt[1]), 32'd0);
    check("wd_ready_3_once", 32'(rdy_cnt[3]), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
